// File: rtl/instruction_queue_pkg.sv
// Shared widths and entry field layout for the fetch-to-dispatch instruction queue.
package instruction_queue_pkg;

  localparam int IQ_DEPTH             = 8;
  localparam int ADDR_WIDTH           = 32;
  localparam int INSTRUCTION_ID_WIDTH = 8;
  localparam int INST_WIDTH           = 32;

  localparam int IQ_ENTRY_WIDTH = ADDR_WIDTH * 2 + INSTRUCTION_ID_WIDTH + INST_WIDTH + 1;

  // Entry layout, LSB first: pc | id | instruction | taken | target
  localparam int IQ_PC_LSB     = 0;
  localparam int IQ_PC_MSB     = IQ_PC_LSB + ADDR_WIDTH - 1;
  localparam int IQ_ID_LSB     = IQ_PC_MSB + 1;
  localparam int IQ_ID_MSB     = IQ_ID_LSB + INSTRUCTION_ID_WIDTH - 1;
  localparam int IQ_INST_LSB   = IQ_ID_MSB + 1;
  localparam int IQ_INST_MSB   = IQ_INST_LSB + INST_WIDTH - 1;
  localparam int IQ_TAKEN_LSB  = IQ_INST_MSB + 1;
  localparam int IQ_TAKEN_MSB  = IQ_TAKEN_LSB;
  localparam int IQ_TARGET_LSB = IQ_TAKEN_MSB + 1;
  localparam int IQ_TARGET_MSB = IQ_TARGET_LSB + ADDR_WIDTH - 1;

  // Concatenation order must mirror the LSB/MSB table above.
  function automatic logic [IQ_ENTRY_WIDTH-1:0] pack_entry(
    input logic [ADDR_WIDTH-1:0]           pc,
    input logic [INSTRUCTION_ID_WIDTH-1:0] id,
    input logic [INST_WIDTH-1:0]           inst,
    input logic                            taken,
    input logic [ADDR_WIDTH-1:0]           target
  );
    return {target, taken, inst, id, pc};
  endfunction

endpackage

// File: rtl/instruction_queue_ram.sv
// Entry storage: register array with two write ports and two asynchronous read ports.
module instruction_queue_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra0,
  output logic [W-1:0]  rd0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // Next array contents; port 1 is applied last so it wins an address clash.
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[wa0] = wd0;
    if (we1) mem_d[wa1] = wd1;
  end

  // Storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

endmodule

// File: rtl/instruction_queue.sv
// Dual-push / dual-pop in-order queue between fetch and dispatch.
// Holds pointers, occupancy, acceptance and the pack/unpack of entry fields.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            push0,
  input  logic                            push1,
  input  logic [ADDR_WIDTH-1:0]           pc0,
  input  logic [ADDR_WIDTH-1:0]           pc1,
  input  logic [INSTRUCTION_ID_WIDTH-1:0] id0,
  input  logic [INSTRUCTION_ID_WIDTH-1:0] id1,
  input  logic [INST_WIDTH-1:0]           instruction0,
  input  logic [INST_WIDTH-1:0]           instruction1,
  input  logic                            branch_taken0,
  input  logic                            branch_taken1,
  input  logic [ADDR_WIDTH-1:0]           branch_taken_address0,
  input  logic [ADDR_WIDTH-1:0]           branch_taken_address1,
  output logic [3:0]                      free,
  output logic                            stall,
  output logic                            overflow,
  output logic                            valid0,
  output logic                            valid1,
  output logic [ADDR_WIDTH-1:0]           q_pc0,
  output logic [ADDR_WIDTH-1:0]           q_pc1,
  output logic [INSTRUCTION_ID_WIDTH-1:0] q_id0,
  output logic [INSTRUCTION_ID_WIDTH-1:0] q_id1,
  output logic [INST_WIDTH-1:0]           q_instruction0,
  output logic [INST_WIDTH-1:0]           q_instruction1,
  output logic                            q_branch_taken0,
  output logic                            q_branch_taken1,
  output logic [ADDR_WIDTH-1:0]           q_branch_taken_address0,
  output logic [ADDR_WIDTH-1:0]           q_branch_taken_address1,
  input  logic                            pop0,
  input  logic                            pop1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          acc0, acc1;
  logic          pop0_ok, pop1_ok;
  logic [PW-1:0] wa1;
  logic [PW-1:0] ra1;

  logic [IQ_ENTRY_WIDTH-1:0] wd0, wd1, rd0, rd1;

  // Free slots come from the registered count only, so same-cycle pops never make room.
  assign free   = 4'(DEPTH) - 4'(count_q);
  assign stall  = (free == 4'd0);
  assign valid0 = (count_q >= CW'(1));
  assign valid1 = (count_q >= CW'(2));

  // Acceptance, compaction and pointer/count update; flush overrides everything.
  always_comb begin
    acc0    = push0 && (free >= 4'd1);
    acc1    = push1 && (free >= (acc0 ? 4'd2 : 4'd1));
    pop0_ok = pop0 && valid0;
    pop1_ok = pop1 && pop0 && valid1;
    wa1     = acc0 ? (tail_q + PW'(1)) : tail_q;
    ra1     = head_q + PW'(1);

    head_d     = head_q + PW'(pop0_ok) + PW'(pop1_ok);
    tail_d     = tail_q + PW'(acc0) + PW'(acc1);
    count_d    = count_q + CW'(acc0) + CW'(acc1) - CW'(pop0_ok) - CW'(pop1_ok);
    overflow_d = (push0 && !acc0) || (push1 && !acc1);

    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // Pointer, occupancy and overflow-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  assign wd0 = pack_entry(pc0, id0, instruction0, branch_taken0, branch_taken_address0);
  assign wd1 = pack_entry(pc1, id1, instruction1, branch_taken1, branch_taken_address1);

  instruction_queue_ram #(
    .DEPTH (DEPTH),
    .W     (IQ_ENTRY_WIDTH)
  ) u_ram (
    .clk (clk),
    .we0 (acc0 && !flush),
    .wa0 (tail_q),
    .wd0 (wd0),
    .we1 (acc1 && !flush),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra0 (head_q),
    .rd0 (rd0),
    .ra1 (ra1),
    .rd1 (rd1)
  );

  assign q_pc0                   = rd0[IQ_PC_MSB:IQ_PC_LSB];
  assign q_id0                   = rd0[IQ_ID_MSB:IQ_ID_LSB];
  assign q_instruction0          = rd0[IQ_INST_MSB:IQ_INST_LSB];
  assign q_branch_taken0         = rd0[IQ_TAKEN_LSB];
  assign q_branch_taken_address0 = rd0[IQ_TARGET_MSB:IQ_TARGET_LSB];

  assign q_pc1                   = rd1[IQ_PC_MSB:IQ_PC_LSB];
  assign q_id1                   = rd1[IQ_ID_MSB:IQ_ID_LSB];
  assign q_instruction1          = rd1[IQ_INST_MSB:IQ_INST_LSB];
  assign q_branch_taken1         = rd1[IQ_TAKEN_LSB];
  assign q_branch_taken_address1 = rd1[IQ_TARGET_MSB:IQ_TARGET_LSB];

endmodule
